// File: rtl/proc_clock_ctrl.sv
// Processor clock-enable and stall controller: divides clk into a one-cycle CPU enable,
// merges stall requests through req/ack, sequences the CPU reset and counts stall cycles.
module proc_clock_ctrl #(
    parameter int NUM_STALL    = 2,
    parameter int DIV_WIDTH    = 8,
    parameter int RESET_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [NUM_STALL-1:0] stall_req_i,
    output logic [NUM_STALL-1:0] stall_ack_o,
    output logic                 proc_ce_o,
    output logic                 proc_rst_n_o,
    output logic [31:0]          stall_cycles_o,
    output logic [1:0]           dbg_state_o
);

    localparam int RCW = $clog2(RESET_CYCLES + 1);
    localparam logic [RCW-1:0] RST_LAST = RCW'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_e;

    // Handshake: stall_ack_o[i] follows stall_req_i[i] one edge later in every state, so a
    // requester that holds req until it sees ack knows the CPU is frozen from that edge on.

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
    logic                 ce_d;
    logic                 prst_n_d;
    logic                 any_req;
    logic                 tick;

    assign any_req = |stall_req_i;
    assign tick    = (cnt_q == div_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        rst_cnt_d = rst_cnt_q;
        ce_d      = 1'b0;
        prst_n_d  = proc_rst_n_o;
        case (state_q)
            ST_RESET: begin
                rst_cnt_d = rst_cnt_q + RCW'(1);
                div_d     = div_i;
                cnt_d     = '0;
                if (rst_cnt_q == RST_LAST) begin
                    prst_n_d = 1'b1;
                    state_d  = any_req ? ST_STALL : ST_RUN;
                end
            end
            ST_RUN: begin
                // A request beats a coincident tick; cnt holds so that enable is only deferred.
                if (any_req) begin
                    state_d = ST_STALL;
                end else if (tick) begin
                    ce_d  = 1'b1;
                    cnt_d = '0;
                    div_d = div_i;
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
            ST_STALL: begin
                if (!any_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RESET;
            cnt_q          <= '0;
            div_q          <= '0;
            rst_cnt_q      <= '0;
            proc_ce_o      <= 1'b0;
            proc_rst_n_o   <= 1'b0;
            stall_ack_o    <= '0;
            stall_cycles_o <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            rst_cnt_q    <= rst_cnt_d;
            proc_ce_o    <= ce_d;
            proc_rst_n_o <= prst_n_d;
            stall_ack_o  <= stall_req_i;
            if (state_q == ST_STALL && stall_cycles_o != 32'hFFFF_FFFF) begin
                stall_cycles_o <= stall_cycles_o + 32'd1;
            end
        end
    end

    assign dbg_state_o = state_q;

endmodule

// File: doc/proc_clock_ctrl.md
# proc_clock_ctrl

Processor clock-enable and stall controller that replaces the gated processor clock in the top level. It runs on the single free-running system clock and produces a one-cycle clock-enable pulse for the CPU at a programmable divide ratio. It merges NUM_STALL stall-request channels (data memory, future peripherals) through a req/ack handshake, sequences the CPU reset after power-up, and counts stalled cycles for performance measurement.

## Interface
- NUM_STALL, 2: number of independent stall-request channels (1..8).
- DIV_WIDTH, 8: width of the divide-ratio input.
- RESET_CYCLES, 16: clk cycles `proc_rst_n_o` is held low after `rst_n` deasserts (≥1).

Ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- div_i  in  DIV_WIDTH  divide ratio: one enable per div_i+1 clk cycles.
- stall_req_i  in  NUM_STALL  per-channel stall request, level.
- stall_ack_o  out  NUM_STALL  per-channel grant: CPU is frozen for this channel.
- proc_ce_o  out  1  CPU clock-enable, one clk cycle wide, registered.
- proc_rst_n_o  out  1  synchronous active-low reset to the CPU, registered.
- stall_cycles_o  out  32  count of clk cycles spent in STALL, saturating at 0xFFFFFFFF.

## Operation
- FSM states: RESET, RUN, STALL. Registered outputs only.
- Reset (rst_n low, asynchronous): state=RESET, divider count=0, reset counter=0, proc_ce_o=0, proc_rst_n_o=0, stall_ack_o=0, stall_cycles_o=0. Asserting rst_n mid-operation aborts any stall or enable immediately.
- RESET: the reset counter increments each clk. After RESET_CYCLES cycles, proc_rst_n_o goes to 1. Next state is STALL if any stall_req_i bit is high, else RUN. proc_ce_o stays 0. Requests in RESET are acknowledged: stall_ack_o[i] <= stall_req_i[i].
- Divider: counter cnt runs 0..div_q, where div_q is div_i captured at each tick and at reset release. tick = (cnt==div_q); cnt <= 0 on tick, else cnt+1. div_i=0 gives a tick every cycle. A div_i change takes effect after the next tick.
- RUN: proc_ce_o <= tick && no stall_req_i bit high. If any stall_req_i bit is high, the next state is STALL and no enable is issued in that cycle.
- STALL: cnt is frozen, so phase is preserved. proc_ce_o=0. stall_ack_o[i] <= stall_req_i[i] each cycle. stall_cycles_o increments once per cycle in STALL. When all stall_req_i bits are low, the next state is RUN and all acks drop in the same edge.
- A new request on another channel during STALL extends the stall. Its ack rises the cycle after its req rises.
- Requesters must hold req high until they see ack. They may drop req any time after ack, and must not perform the stalled access before ack=1.

## Timing
- Stall entry: req rises before edge N. At edge N, state=STALL, proc_ce_o=0, ack=1. The enable suppressed at edge N is not lost; it is deferred, because cnt is frozen.
- Stall exit: last req falls before edge M. At edge M, state=RUN and ack=0. The first enable can appear at edge M+1 if cnt==div_q.
- Enable latency: a tick in RUN yields proc_ce_o high for exactly one cycle on the following edge.
- Maximum CPU enable rate is one per clk (div_i=0). The CPU and data memory both use clk qualified by proc_ce_o. No derived or gated clocks.
- A request in the same cycle as a tick wins: no enable is issued.

## Test plan
- Reset sequence: rst_n low 3 cycles, then high, div_i=0, no requests -> proc_rst_n_o=0 for exactly 16 cycles after release, then 1; proc_ce_o high every cycle from the following edge.
- Divide: div_i=3, no stalls, 40 cycles in RUN -> proc_ce_o pulses every 4 cycles, 10 pulses, each 1 cycle wide. Change div_i to 1 mid-run -> the period becomes 2 after the next pulse.
- Single stall: div_i=0, stall_req_i[0] high 5 cycles -> ack[0] high 5 cycles starting 1 edge later, proc_ce_o low for those 5 edges, stall_cycles_o=5, enables resume the edge after ack falls.
- Overlapping stalls: req[0] cycles 10–14, req[1] cycles 12–20 -> state STALL continuously from 11 to 21, ack[0] 11–15, ack[1] 13–21, stall_cycles_o=11.
- Phase preservation: div_i=3, stall asserted when cnt=2 for 6 cycles -> the first post-stall enable occurs 1 tick-cycle after resume (cnt continues from 2), not 4.
- Reset mid-stall: req[0] held, rst_n pulsed low -> all outputs are 0 asynchronously. After release, ack[0]=1 during RESET, and the FSM enters STALL, not RUN, at the end of reset.
